// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the sequential ripple-carry adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rca_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover the full operand width.
    function automatic int calc_n(input int width, input int slice);
        return width / slice;
    endfunction

    // Chunk counter width; never narrower than one bit so N=1 still elaborates.
    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_seq_add_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_add_ctrl; RCA_SEQ_ADD_SUB_EN adds sub/ovf.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and result sides.
interface rca_seq_add_ctrl_if #(
    parameter int WIDTH = rca_seq_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RCA_SEQ_ADD_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/rca_slice.sv
// SLICE-bit ripple-carry adder made of a chain of 1-bit full-adder cells.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the result is consumed.
module rca_slice #(
    parameter int SLICE = rca_seq_pkg::DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Wide add sequencer: one shared rca_slice walks WIDTH/SLICE chunks LSB first (RCA_SEQ_ADD_SUB_EN adds subtract).
// Latency: accept at edge T, out_valid at edge T+N; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module rca_seq_add_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_seq_add_ctrl_if.slave    io
);

    localparam int N  = calc_n(WIDTH, SLICE);
    localparam int CW = calc_cw(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("rca_seq_add_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             in_rdy;
    logic             out_vld;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_sum;
    logic             sl_co;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs, decoded from the current state.
    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (io.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route chunk cnt_q of each operand into the shared slice.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                sl_a = a_q[k*SLICE +: SLICE];
                sl_b = b_q[k*SLICE +: SLICE];
            end
        end
    end

    rca_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_co)
    );

`ifdef RCA_SEQ_ADD_SUB_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the chunk MSB, recovered from the slice sum bit.
    assign msb_cin = sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_sum[SLICE-1];

    // Overflow flag; the last RUN chunk leaves the full-width value behind.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN) begin
            ovf_q <= msb_cin ^ sl_co;
        end
    end

    assign io.ovf = out_vld & ovf_q;
`endif

    // Operand capture at accept, then one chunk per RUN cycle into sum/carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q   <= io.a;
            cnt_q <= '0;
`ifdef RCA_SEQ_ADD_SUB_EN
            // Subtract as A + ~B + 1; the caller's cin is irrelevant then.
            b_q     <= io.sub ? ~io.b : io.b;
            carry_q <= io.sub ? 1'b1 : io.cin;
`else
            b_q     <= io.b;
            carry_q <= io.cin;
`endif
        end else if (state_q == RUN) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_q == CW'(k)) begin
                    sum_q[k*SLICE +: SLICE] <= sl_sum;
                end
            end
            carry_q <= sl_co;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.sum       = sum_q;
    assign io.cout      = out_vld & carry_q;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed bench for rca_seq_add_ctrl in the 32/8 configuration (RCA_SEQ_ADD_SUB_EN adds subtract vectors).
// Latency: expects out_valid 4 edges after accept and one accept every 6 cycles when streaming.
// Backpressure: exercises out_ready held low in DONE and in_valid ignored outside IDLE.
module tb_rca_seq_add_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rca_seq_add_ctrl_if #(.WIDTH(W)) io ();

    rca_seq_add_ctrl #(
        .WIDTH (W),
        .SLICE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Steps until out_valid, counting edges; gives up after 50 edges.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!io.out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!io.out_valid) chk("out_valid_timeout", {63'b0, io.out_valid}, 64'd1);
    endtask

    // Presents one operand pair for a single edge; the DUT must be in IDLE.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        chk("accept_ready", {63'b0, io.in_ready}, 64'd1);
        io.a        = av;
        io.b        = bv;
        io.cin      = c;
        io.in_valid = 1'b1;
        step();
        io.in_valid = 1'b0;
    endtask

    task automatic handshake();
        io.out_ready = 1'b1;
        step();
        io.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int t;
        int last_t;
        int g;
        logic [W:0] e;

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.cin       = 1'b0;
        io.out_ready = 1'b0;
`ifdef RCA_SEQ_ADD_SUB_EN
        io.sub       = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {63'b0, io.in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, io.out_valid}, 64'd0);
        chk("rst_sum", {32'b0, io.sum}, 64'h0);
        chk("rst_cout", {63'b0, io.cout}, 64'd0);

        // 0xFF + 1: carry into chunk 1
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("t1_busy", {63'b0, io.in_ready}, 64'd0);
        wait_out(lat);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_sum", {32'b0, io.sum}, 64'h0000_0100);
        chk("t1_cout", {63'b0, io.cout}, 64'd0);
        handshake();
        chk("t1_idle_ready", {63'b0, io.in_ready}, 64'd1);

        // All-ones + 0 + cin: carry ripples through every chunk
        accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_out(lat);
        chk("t2_latency", 64'(lat), 64'd4);
        chk("t2_sum", {32'b0, io.sum}, 64'h0);
        chk("t2_cout", {63'b0, io.cout}, 64'd1);

        // Hold the result for 10 cycles while offering a new operand
        io.a        = 32'hDEAD_BEEF;
        io.b        = 32'h0000_0001;
        io.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", {63'b0, io.out_valid}, 64'd1);
            chk("hold_sum", {32'b0, io.sum}, 64'h0);
            chk("hold_cout", {63'b0, io.cout}, 64'd1);
            chk("hold_in_ready", {63'b0, io.in_ready}, 64'd0);
        end
        io.in_valid = 1'b0;
        handshake();
        chk("t3_in_ready", {63'b0, io.in_ready}, 64'd1);
        chk("t3_out_valid", {63'b0, io.out_valid}, 64'd0);
        chk("t3_sum_held", {32'b0, io.sum}, 64'h0);
        step();
        chk("t3_no_accept_ready", {63'b0, io.in_ready}, 64'd1);
        chk("t3_no_accept_valid", {63'b0, io.out_valid}, 64'd0);

        // Reset during the 2nd RUN cycle aborts the operation
        accept(32'h1234_5678, 32'h1111_1111, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", {63'b0, io.in_ready}, 64'd1);
        chk("abort_out_valid", {63'b0, io.out_valid}, 64'd0);
        chk("abort_sum", {32'b0, io.sum}, 64'h0);
        chk("abort_cout", {63'b0, io.cout}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_result", {63'b0, io.out_valid}, 64'd0);
        end

        // Streaming: in_valid and out_ready held high
        io.out_ready = 1'b1;
        last_t = 0;
        for (int i = 0; i < 100; i++) begin
            io.a        = $urandom;
            io.b        = $urandom;
            io.cin      = 1'($urandom_range(0, 1));
            io.in_valid = 1'b1;
            g = 0;
            while (!io.in_ready && g < 20) begin
                step();
                g++;
            end
            chk("b2b_ready", {63'b0, io.in_ready}, 64'd1);
            e = {1'b0, io.a} + {1'b0, io.b} + {{W{1'b0}}, io.cin};
            t = edge_cnt;
            step();
            if (i > 0) chk("b2b_gap", 64'(t - last_t), 64'd6);
            last_t = t;
            wait_out(lat);
            chk("b2b_sum", {32'b0, io.sum}, {32'b0, e[W-1:0]});
            chk("b2b_cout", {63'b0, io.cout}, {63'b0, e[W]});
        end
        io.in_valid = 1'b0;
        step();
        io.out_ready = 1'b0;
        chk("b2b_idle", {63'b0, io.in_ready}, 64'd1);

`ifdef RCA_SEQ_ADD_SUB_EN
        // Subtract: most negative minus one overflows
        io.sub = 1'b1;
        accept(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_out(lat);
        chk("sub1_sum", {32'b0, io.sum}, 64'h7FFF_FFFF);
        chk("sub1_cout", {63'b0, io.cout}, 64'd1);
        chk("sub1_ovf", {63'b0, io.ovf}, 64'd1);
        handshake();

        // Subtract with borrow, cin ignored
        accept(32'h0000_0005, 32'h0000_0007, 1'b1);
        wait_out(lat);
        chk("sub2_sum", {32'b0, io.sum}, 64'hFFFF_FFFE);
        chk("sub2_cout", {63'b0, io.cout}, 64'd0);
        chk("sub2_ovf", {63'b0, io.ovf}, 64'd0);
        handshake();
        io.sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
